// File: rtl/fpm_issue_arb.sv
// Issue arbiter and pipeline-valid tracker for a LAT-stage multiplier shared by requesters A and B.
// Optional grant counters are enabled by defining FPM_ARB_PERF_CNT_EN.
module fpm_issue_arb #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        req_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        sel,
    output logic        issue,
    output logic        pipe_en,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        out_id,
    output logic [3:0]  occ,
    output logic [1:0]  st,
    output logic [15:0] cnt_a,
    output logic [15:0] cnt_b
);

    // state | meaning
    // IDLE  | no operation in flight
    // RUN   | operations in flight, pipeline advancing
    // STALL | final stage held by downstream back-pressure
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } st_e;

    function automatic logic [3:0] popcnt(input logic [LAT-1:0] x);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < LAT; i++) begin
            c = c + {3'b000, x[i]};
        end
        return c;
    endfunction

    logic [LAT-1:0] v_q, v_d;
    logic [LAT-1:0] id_q, id_d;
    logic           rr_q, rr_d;   // last granted requester: 0=A, 1=B
    st_e            st_q, st_d;
    logic           gnt_ok;

    assign pipe_en   = !(v_q[LAT-1] && !out_ready);
    assign out_valid = v_q[LAT-1];
    assign out_id    = id_q[LAT-1];
    assign occ       = popcnt(v_q);
    assign st        = st_q;

    always_comb begin
        gnt_ok = pipe_en && !flush && !rst;
        gnt_a  = gnt_ok && req_a && (!req_b || rr_q);
        gnt_b  = gnt_ok && req_b && (!req_a || !rr_q);
        issue  = gnt_a || gnt_b;
        sel    = gnt_b;
    end

    always_comb begin
        v_d  = v_q;
        id_d = id_q;
        rr_d = rr_q;
        if (flush) begin
            v_d  = '0;
            id_d = '0;
        end else if (pipe_en) begin
            v_d  = {v_q[LAT-2:0], issue};
            id_d = {id_q[LAT-2:0], sel};
        end
        if (issue) begin
            rr_d = sel;
        end
    end

    always_comb begin
        st_d = st_q;
        if (flush) begin
            st_d = ST_IDLE;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (issue) st_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!pipe_en)                            st_d = ST_STALL;
                    else if (popcnt(v_d) == 4'd0 && !issue) st_d = ST_IDLE;
                end
                ST_STALL: begin
                    if (out_ready) st_d = ST_RUN;
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '0;
            id_q <= '0;
            rr_q <= 1'b1;
            st_q <= ST_IDLE;
        end else begin
            v_q  <= v_d;
            id_q <= id_d;
            rr_q <= rr_d;
            st_q <= st_d;
        end
    end

`ifdef FPM_ARB_PERF_CNT_EN
    logic [15:0] cnt_a_q, cnt_a_d;
    logic [15:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (gnt_a) cnt_a_d = cnt_a_q + 16'd1;
        if (gnt_b) cnt_b_d = cnt_b_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`else
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_fpm_issue_arb.sv
// Directed self-checking bench for fpm_issue_arb with LAT=4.
module tb_fpm_issue_arb;

    logic        clk, rst;
    logic        req_a, req_b, flush, out_ready;
    logic        gnt_a, gnt_b, sel, issue, pipe_en, out_valid, out_id;
    logic [3:0]  occ;
    logic [1:0]  st;
    logic [15:0] cnt_a, cnt_b;

    int nvec = 0;
    int nerr = 0;

    fpm_issue_arb #(.LAT(4)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .sel(sel), .issue(issue), .pipe_en(pipe_en),
        .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_id(out_id),
        .occ(occ), .st(st),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic ra, input logic rb, input logic rdy, input logic fl);
        req_a = ra; req_b = rb; out_ready = rdy; flush = fl;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        #1;
        nvec++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin nerr++; $display("FAIL reset_gnt: gnt_a=%b gnt_b=%b want 0 0", gnt_a, gnt_b); end
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_ov: got %b want 0", out_valid); end
        nvec++; if (occ !== 4'd0) begin nerr++; $display("FAIL reset_occ: got %0d want 0", occ); end
        nvec++; if (st !== 2'd0) begin nerr++; $display("FAIL reset_st: got %0d want 0", st); end
        nvec++; if (pipe_en !== 1'b1) begin nerr++; $display("FAIL reset_pipe_en: got %b want 1", pipe_en); end
        nvec++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin nerr++; $display("FAIL reset_cnt: got %h %h want 0 0", cnt_a, cnt_b); end
    endtask

    task automatic test_single_latency();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        nvec++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || issue !== 1'b1 || sel !== 1'b0) begin
            nerr++; $display("FAIL single_gnt: gnt_a=%b gnt_b=%b issue=%b sel=%b want 1 0 1 0", gnt_a, gnt_b, issue, sel);
        end
        tick();
        for (int k = 1; k <= 7; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            nvec++; if (out_valid !== (k == 4)) begin nerr++; $display("FAIL single_ov_c%0d: got %b want %b", k, out_valid, (k == 4)); end
            if (k == 4) begin
                nvec++; if (out_id !== 1'b0) begin nerr++; $display("FAIL single_id: got %b want 0", out_id); end
            end
            if (k == 1) begin
                nvec++; if (st !== 2'd1 || occ !== 4'd1) begin nerr++; $display("FAIL single_run: st=%0d occ=%0d want 1 1", st, occ); end
            end
            if (k == 5) begin
                nvec++; if (st !== 2'd0 || occ !== 4'd0) begin nerr++; $display("FAIL single_idle: st=%0d occ=%0d want 0 0", st, occ); end
            end
            tick();
        end
    endtask

    task automatic test_rr_alternate();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            nvec++; if (gnt_a !== (k % 2 == 0) || gnt_b !== (k % 2 == 1)) begin
                nerr++; $display("FAIL rr_gnt_c%0d: gnt_a=%b gnt_b=%b want %b %b", k, gnt_a, gnt_b, (k % 2 == 0), (k % 2 == 1));
            end
            nvec++; if (occ !== ((k < 4) ? k[3:0] : 4'd4)) begin nerr++; $display("FAIL rr_occ_c%0d: got %0d want %0d", k, occ, (k < 4) ? k : 4); end
            nvec++; if (out_valid !== (k >= 4)) begin nerr++; $display("FAIL rr_ov_c%0d: got %b want %b", k, out_valid, (k >= 4)); end
            if (k >= 4) begin
                nvec++; if (out_id !== ((k - 4) % 2 == 1)) begin nerr++; $display("FAIL rr_id_c%0d: got %b want %b", k, out_id, ((k - 4) % 2 == 1)); end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp_id;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            tick();
        end
        for (int k = 4; k < 7; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            nvec++; if (pipe_en !== 1'b0 || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
                nerr++; $display("FAIL stall_hold_c%0d: pipe_en=%b gnt_a=%b gnt_b=%b want 0 0 0", k, pipe_en, gnt_a, gnt_b);
            end
            nvec++; if (out_valid !== 1'b1 || out_id !== 1'b0) begin nerr++; $display("FAIL stall_out_c%0d: ov=%b id=%b want 1 0", k, out_valid, out_id); end
            nvec++; if (st !== ((k == 4) ? 2'd1 : 2'd2)) begin nerr++; $display("FAIL stall_st_c%0d: got %0d want %0d", k, st, (k == 4) ? 1 : 2); end
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        nvec++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || pipe_en !== 1'b1) begin
            nerr++; $display("FAIL stall_release: gnt_a=%b gnt_b=%b pipe_en=%b want 1 0 1", gnt_a, gnt_b, pipe_en);
        end
        nvec++; if (st !== 2'd2) begin nerr++; $display("FAIL stall_st_c7: got %0d want 2", st); end
        tick();
        exp_id = 4'b0101;  // out_id for cycles 8..11 (bit index = cycle-8)
        for (int k = 8; k < 13; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            nvec++; if (out_valid !== (k < 12)) begin nerr++; $display("FAIL resume_ov_c%0d: got %b want %b", k, out_valid, (k < 12)); end
            if (k < 12) begin
                nvec++; if (out_id !== exp_id[k-8]) begin nerr++; $display("FAIL resume_id_c%0d: got %b want %b", k, out_id, exp_id[k-8]); end
            end
            if (k == 8) begin
                nvec++; if (st !== 2'd1) begin nerr++; $display("FAIL resume_st: got %0d want 1", st); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        nvec++; if (occ !== 4'd3 || st !== 2'd1) begin nerr++; $display("FAIL flush_pre: occ=%0d st=%0d want 3 1", occ, st); end
        nvec++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin nerr++; $display("FAIL flush_gnt: gnt_a=%b gnt_b=%b want 0 0", gnt_a, gnt_b); end
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        nvec++; if (occ !== 4'd0 || st !== 2'd0) begin nerr++; $display("FAIL flush_post: occ=%0d st=%0d want 0 0", occ, st); end
        nvec++; if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin nerr++; $display("FAIL flush_rr: gnt_a=%b gnt_b=%b want 0 1", gnt_a, gnt_b); end
        tick();
        for (int k = 5; k < 10; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            nvec++; if (out_valid !== (k == 8)) begin nerr++; $display("FAIL flush_ov_c%0d: got %b want %b", k, out_valid, (k == 8)); end
            if (k == 8) begin
                nvec++; if (out_id !== 1'b1) begin nerr++; $display("FAIL flush_id: got %b want 1", out_id); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
        nvec++; if (st !== 2'd2 || occ !== 4'd2) begin nerr++; $display("FAIL rstmid_pre: st=%0d occ=%0d want 2 2", st, occ); end
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        nvec++; if (gnt_a !== 1'b0) begin nerr++; $display("FAIL rstmid_gnt: got %b want 0", gnt_a); end
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        nvec++; if (out_valid !== 1'b0 || occ !== 4'd0 || st !== 2'd0 || pipe_en !== 1'b1) begin
            nerr++; $display("FAIL rstmid_post: ov=%b occ=%0d st=%0d pipe_en=%b want 0 0 0 1", out_valid, occ, st, pipe_en);
        end
        nvec++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin nerr++; $display("FAIL rstmid_cnt: got %h %h want 0 0", cnt_a, cnt_b); end
        for (int k = 0; k < 5; k++) begin
            tick();
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_ghost_%0d: got %b want 0", k, out_valid); end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        nvec++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin nerr++; $display("FAIL rstmid_rr: gnt_a=%b gnt_b=%b want 1 0", gnt_a, gnt_b); end
        tick();
    endtask

    task automatic test_counters();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, (k < 4), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef FPM_ARB_PERF_CNT_EN
        // both requesting for 4 cycles gives A,B,A,B then A alone twice
        nvec++; if (cnt_a !== 16'd4 || cnt_b !== 16'd2) begin nerr++; $display("FAIL cnt_mix: got %0d %0d want 4 2", cnt_a, cnt_b); end
        do_reset();
        for (int k = 0; k < 65535; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        nvec++; if (cnt_a !== 16'hFFFF) begin nerr++; $display("FAIL cnt_max: got %h want ffff", cnt_a); end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        nvec++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin nerr++; $display("FAIL cnt_wrap: got %h %h want 0 0", cnt_a, cnt_b); end
`else
        nvec++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin nerr++; $display("FAIL cnt_tied: got %h %h want 0 0", cnt_a, cnt_b); end
`endif
        tick();
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; flush = 1'b0; out_ready = 1'b1;
        test_reset();
        test_single_latency();
        test_rr_alternate();
        test_stall();
        test_flush();
        test_reset_mid();
        test_counters();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
